// File: rtl/muldiv_if.sv
// Request/result bundle for the muldiv unit: operation launch, HI/LO direct writes
// and the architectural HI/LO state.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv.sv
// Iterative multiply/divide unit with HI/LO registers (one bit per cycle, sign fix-up last).
// Divide ops are built only when MULDIV_DIV_EN is defined; otherwise DIVU/DIV starts are ignored.
module muldiv #(
  parameter int WIDTH = 32
) (
  input logic     clk_i,
  input logic     rst_i,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;

  logic               op_ok_s;
  logic               accept_s;
  logic               last_s;
  logic               signed_s;
  logic [WIDTH-1:0]   mag_a_s;
  logic [WIDTH-1:0]   mag_b_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] mul_next_s;
  logic [2*WIDTH-1:0] prod_s;
`ifdef MULDIV_DIV_EN
  logic               is_div_q, is_div_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;
  logic [WIDTH:0]     div_shift_s;
  logic               div_ge_s;
  logic [WIDTH-1:0]   div_diff_s;
  logic [2*WIDTH-1:0] div_next_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;
`endif

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    if (sgn && v[WIDTH-1]) begin
      return -v;
    end else begin
      return v;
    end
  endfunction

`ifdef MULDIV_DIV_EN
  assign op_ok_s = 1'b1;
`else
  assign op_ok_s = ~bus.op[1];
`endif

  assign accept_s = bus.start & ~busy_q & op_ok_s;
  assign last_s   = (cnt_q == CW'(WIDTH - 1));
  assign signed_s = bus.op[0];
  assign mag_a_s  = magnitude(bus.a, signed_s);
  assign mag_b_s  = magnitude(bus.b, signed_s);

  // Shift-add: p holds {partial sum, remaining multiplier bits}, opnd is the multiplicand.
  assign mul_sum_s  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_next_s = {mul_sum_s, p_q[WIDTH-1:1]};
  assign prod_s     = neg_q ? -p_q : p_q;

`ifdef MULDIV_DIV_EN
  // Restoring divide: p holds {remainder, dividend/quotient}, opnd is the divisor.
  assign div_shift_s = p_q[2*WIDTH-1:WIDTH-1];
  assign div_ge_s    = (div_shift_s >= {1'b0, opnd_q});
  assign div_diff_s  = div_shift_s[WIDTH-1:0] - opnd_q;
  assign div_next_s  = div_ge_s ? {div_diff_s, p_q[WIDTH-2:0], 1'b1}
                                : {div_shift_s[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
  assign quo_s = dz_q ? {WIDTH{1'b1}} : (neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0]);
  assign rem_s = rneg_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (last_s) begin
          state_d = S_FIX;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    p_d    = p_q;
    cnt_d  = cnt_q;
    neg_d  = neg_q;
`ifdef MULDIV_DIV_EN
    is_div_d = is_div_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          busy_d = 1'b1;
          cnt_d  = {CW{1'b0}};
          neg_d  = signed_s & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
`ifdef MULDIV_DIV_EN
          is_div_d = bus.op[1];
          rneg_d   = signed_s & bus.a[WIDTH-1];
          dz_d     = (bus.b == {WIDTH{1'b0}});
          if (bus.op[1]) begin
            opnd_d = mag_b_s;
            p_d    = {{WIDTH{1'b0}}, mag_a_s};
          end else begin
            opnd_d = mag_a_s;
            p_d    = {{WIDTH{1'b0}}, mag_b_s};
          end
`else
          opnd_d = mag_a_s;
          p_d    = {{WIDTH{1'b0}}, mag_b_s};
`endif
        end else begin
          if (bus.hi_we) begin
            hi_d = bus.wdata;
          end else begin
            hi_d = hi_q;
          end
          if (bus.lo_we) begin
            lo_d = bus.wdata;
          end else begin
            lo_d = lo_q;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CW'(1);
`ifdef MULDIV_DIV_EN
        p_d = is_div_q ? div_next_s : mul_next_s;
`else
        p_d = mul_next_s;
`endif
      end
      S_FIX: begin
        busy_d = 1'b0;
        done_d = 1'b1;
`ifdef MULDIV_DIV_EN
        if (is_div_q) begin
          hi_d = rem_s;
          lo_d = quo_s;
        end else begin
          hi_d = prod_s[2*WIDTH-1:WIDTH];
          lo_d = prod_s[WIDTH-1:0];
        end
`else
        hi_d = prod_s[2*WIDTH-1:WIDTH];
        lo_d = prod_s[WIDTH-1:0];
`endif
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= {WIDTH{1'b0}};
      lo_q   <= {WIDTH{1'b0}};
      opnd_q <= {WIDTH{1'b0}};
      p_q    <= {(2*WIDTH){1'b0}};
      cnt_q  <= {CW{1'b0}};
      neg_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div_q <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
`endif
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
      p_q    <= p_d;
      cnt_q  <= cnt_d;
      neg_q  <= neg_d;
`ifdef MULDIV_DIV_EN
      is_div_q <= is_div_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv.sv
// Directed-vector bench for muldiv (WIDTH=32); divide vectors run only with MULDIV_DIV_EN.
module tb_muldiv;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   lat;
  int   pulses;
  int   busy_seen;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv #(.WIDTH(W)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int l);
    l = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (bus.done === 1'b1) begin
        l = i;
        break;
      end
    end
  endtask

  task automatic idle_watch(input int n, output int p, output int b);
    p = 0;
    b = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.done === 1'b1) p++;
      if (bus.busy === 1'b1) b++;
    end
  endtask

  task automatic launch(input logic [1:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v);
    bus.op    = op_v;
    bus.a     = a_v;
    bus.b     = b_v;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.op    = op_v ^ 2'b11;
    bus.a     = ~a_v;
    bus.b     = 32'h5A5A_5A5A;
  endtask

  task automatic run_op(input string tag, input logic [1:0] op_v, input logic [31:0] a_v,
                        input logic [31:0] b_v, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int l;
    launch(op_v, a_v, b_v);
    wait_done(l);
    check({tag, "_lat"}, 64'(l), 64'd33);
    check({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
    tick();
    check({tag, "_done1"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = 2'd0;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'hCAFE_F00D;
    rst       = 1'b1;
    tick();
    tick();
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    rst       = 1'b0;
    tick();

    bus.wdata = 32'h1234_5678;
    bus.hi_we = 1'b1;
    tick();
    bus.hi_we = 1'b0;
    check("mthi", 64'(bus.hi), 64'h1234_5678);
    bus.wdata = 32'h9ABC_DEF0;
    bus.lo_we = 1'b1;
    tick();
    bus.lo_we = 1'b0;
    check("mtlo", 64'(bus.lo), 64'h9ABC_DEF0);
    check("mtlo_hi_kept", 64'(bus.hi), 64'h1234_5678);

    // start and hi_we together: the write must be dropped
    bus.hi_we = 1'b1;
    bus.wdata = 32'hDEAD_BEEF;
    launch(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    bus.hi_we = 1'b0;
    check("start_busy", 64'(bus.busy), 64'd1);
    check("start_wins_hi", 64'(bus.hi), 64'h1234_5678);
    wait_done(lat);
    check("multu_max_lat", 64'(lat), 64'd33);
    check("multu_max_hi", 64'(bus.hi), 64'hFFFF_FFFE);
    check("multu_max_lo", 64'(bus.lo), 64'h0000_0001);
    check("multu_max_busy", 64'(bus.busy), 64'd0);
    tick();
    check("multu_max_done1", 64'(bus.done), 64'd0);

    run_op("mult_m3x5", 2'd1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("mult_m1xm1", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1);
    run_op("multu_2p16sq", 2'd0, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0);
    run_op("mult_minx2", 2'd1, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 32'h0);

    // second start and lo_we during a running MULTU are ignored
    launch(2'd0, 32'd3, 32'd4);
    for (int i = 0; i < 4; i++) tick();
    bus.op    = 2'd0;
    bus.a     = 32'd100;
    bus.b     = 32'd100;
    bus.start = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h5555_5555;
    tick();
    bus.start = 1'b0;
    bus.lo_we = 1'b0;
    check("busy_lo_we_ignored", 64'(bus.lo), 64'h0);
    wait_done(lat);
    check("ign_lat", 64'(lat + 5), 64'd33);
    check("ign_hi", 64'(bus.hi), 64'h0);
    check("ign_lo", 64'(bus.lo), 64'd12);
    idle_watch(40, pulses, busy_seen);
    check("ign_no_queue_done", 64'(pulses), 64'd0);
    check("ign_no_queue_busy", 64'(busy_seen), 64'd0);

    // reset in the middle of a MULT
    launch(2'd1, 32'hFFFF_FFFD, 32'd5);
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_hi", 64'(bus.hi), 64'h0);
    check("abort_lo", 64'(bus.lo), 64'h0);
    check("abort_done", 64'(bus.done), 64'd0);
    idle_watch(40, pulses, busy_seen);
    check("abort_no_done", 64'(pulses), 64'd0);
    run_op("multu_7x6", 2'd0, 32'd7, 32'd6, 32'h0, 32'd42);

`ifdef MULDIV_DIV_EN
    run_op("div_m7d2", 2'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_ovf", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_op("divu_by0", 2'd2, 32'd10, 32'd0, 32'h0000_000A, 32'hFFFF_FFFF);
    run_op("divu_100d7", 2'd2, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div_7dm2", 2'd3, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    run_op("div_m7by0", 2'd3, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
`else
    bus.wdata = 32'hAAAA_0001;
    bus.hi_we = 1'b1;
    tick();
    bus.hi_we = 1'b0;
    bus.wdata = 32'hBBBB_0002;
    bus.lo_we = 1'b1;
    tick();
    bus.lo_we = 1'b0;
    launch(2'd2, 32'd10, 32'd3);
    check("nodiv_divu_busy", 64'(bus.busy), 64'd0);
    idle_watch(40, pulses, busy_seen);
    check("nodiv_divu_done", 64'(pulses), 64'd0);
    check("nodiv_divu_busy_seen", 64'(busy_seen), 64'd0);
    check("nodiv_divu_hi", 64'(bus.hi), 64'hAAAA_0001);
    check("nodiv_divu_lo", 64'(bus.lo), 64'hBBBB_0002);
    launch(2'd3, 32'hFFFF_FFF9, 32'd2);
    idle_watch(40, pulses, busy_seen);
    check("nodiv_div_done", 64'(pulses), 64'd0);
    check("nodiv_div_busy_seen", 64'(busy_seen), 64'd0);
    check("nodiv_div_lo", 64'(bus.lo), 64'hBBBB_0002);
    run_op("nodiv_multu_5x9", 2'd0, 32'd5, 32'd9, 32'h0, 32'd45);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
